// File: rtl/sha256_msg_seq.sv
// sha256_msg_seq: pads a 1..55 byte message into one SHA-256 block, runs the core, streams the digest
module sha256_msg_seq #(
    parameter int IRQ_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [6:0] o_core_addr,
    output logic [7:0] o_core_data,
    output logic       o_core_we,
    input  logic [7:0] i_core_data,
    input  logic       i_core_irq,
    output logic       o_busy,
    output logic       o_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] PAD   = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] READ  = 3'd5;
    localparam logic [2:0] DRAIN = 3'd6;
    localparam int TW = $clog2(IRQ_TIMEOUT + 1);

    logic [2:0]    state, state_n;
    logic [5:0]    len, k;
    logic [4:0]    j;
    logic [TW-1:0] tcnt;
    logic          acc, tout, hs_end, cap;
    logic [7:0]    pad_byte;

    assign s_ready  = (state == IDLE) | (state == RECV) | (state == DRAIN);
    assign acc      = s_valid & s_ready;
    assign tout     = tcnt == TW'(IRQ_TIMEOUT - 1);
    assign hs_end   = m_valid & m_ready & m_last;
    // the read address only points at digest byte 0 once WAIT has had a cycle to set it
    assign cap      = (state == WAIT & i_core_irq & o_core_addr == 7'd101) |
                      (state == READ & !hs_end & (!m_valid | m_ready));
    assign pad_byte = (k == len)    ? 8'h80 :
                      (k == 6'd62)  ? {7'd0, len[5]} :
                      (k == 6'd63)  ? {len[4:0], 3'd0} : 8'h00;

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (acc) state_n = s_last ? PAD : RECV;
            RECV:    if (acc) state_n = (len == 6'd55) ? (s_last ? IDLE : DRAIN) : (s_last ? PAD : RECV);
            PAD:     if (k == 6'd63) state_n = START;
            START:   state_n = WAIT;
            WAIT:    state_n = i_core_irq ? READ : (tout ? IDLE : WAIT);
            READ:    if (hs_end) state_n = IDLE;
            DRAIN:   if (acc & s_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register and registered busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= state_n;
            o_busy <= state_n != IDLE;
        end
    end

    // core bus writes, message length, pad index, timeout counter and error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len         <= '0;
            k           <= '0;
            tcnt        <= '0;
            o_core_we   <= 1'b0;
            o_core_addr <= '0;
            o_core_data <= '0;
            o_err       <= 1'b0;
        end else begin
            o_core_we <= 1'b0;
            o_err     <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    o_core_we   <= 1'b1;
                    o_core_addr <= 7'd63;
                    o_core_data <= s_data;
                    len         <= 6'd1;
                    k           <= 6'd1;
                end
                RECV: if (acc) begin
                    if (len == 6'd55) begin
                        o_err <= 1'b1;
                    end else begin
                        o_core_we   <= 1'b1;
                        o_core_addr <= {1'b0, 6'd63 - len};
                        o_core_data <= s_data;
                        len         <= len + 6'd1;
                        k           <= len + 6'd1;
                    end
                end
                PAD: begin
                    o_core_we   <= 1'b1;
                    o_core_addr <= {1'b0, 6'd63 - k};
                    o_core_data <= pad_byte;
                    k           <= k + 6'd1;
                end
                START: begin
                    o_core_we   <= 1'b1;
                    o_core_addr <= 7'd65;
                    o_core_data <= 8'h01;
                    tcnt        <= '0;
                end
                WAIT: begin
                    o_core_addr <= cap ? 7'd100 : 7'd101;
                    tcnt        <= (i_core_irq | tout) ? '0 : tcnt + TW'(1);
                    o_err       <= !i_core_irq & tout;
                end
                READ: if (cap) o_core_addr <= 7'd100 - {2'd0, j};
                default: ;
            endcase
        end
    end

    // digest output stage with ready/valid hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            j       <= '0;
        end else if (cap) begin
            m_data  <= i_core_data;
            m_valid <= 1'b1;
            m_last  <= j == 5'd31;
            j       <= j + 5'd1;
        end else if (state == READ && hs_end) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (state == START) begin
            j <= '0;
        end
    end
endmodule
